// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//
// Streaming K x K sliding-window generator for the convolution front end.
// Pixels arrive one per valid beat in raster order. K-1 line buffers hold the
// rows above the current one, and a K x K register holds the live window. When
// the newest pixel lands on the stride grid, the whole window is registered to
// the output with frame-position flags.
//
// Handshake: ivalid qualifies idata. There is no ready, so every beat with
// ivalid=1 is consumed. ovalid is a one-cycle pulse per window, and the
// consumer must take every pulse. osof, oeof, orow and ocol are meaningful
// only while ovalid=1. odata holds its last window between pulses.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset (counters and outputs only)
//   iclear  synchronous frame restart; an accompanying pixel becomes (0,0)
//   ivalid  idata carries a pixel this cycle
//   idata   pixel, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   ovalid  odata holds a freshly completed window
//   odata   window, element (r,c) at [((r*K+c)*CH*DATA_WIDTH) +: CH*DATA_WIDTH]
//           r=0 is the oldest row, c=0 is the leftmost column
//   osof    first window of the frame
//   oeof    last window of the frame
//   orow    output-window row index
//   ocol    output-window column index
// -----------------------------------------------------------------------------
module conv_window_gen #(
  parameter int DATA_WIDTH = 6,
  parameter int K          = 3,
  parameter int CH         = 1,
  parameter int IMG_W      = 9,
  parameter int IMG_H      = 9,
  parameter int STRIDE     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             iclear,
  input  logic                             ivalid,
  input  logic [CH*DATA_WIDTH-1:0]         idata,
  output logic                             ovalid,
  output logic [K*K*CH*DATA_WIDTH-1:0]     odata,
  output logic                             osof,
  output logic                             oeof,
  output logic [$clog2(IMG_H)-1:0]         orow,
  output logic [$clog2(IMG_W)-1:0]         ocol
);

  localparam int PW    = CH * DATA_WIDTH;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int PHW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

  localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  COL_START  = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_START  = RW'(K - 1);
  localparam logic [CW-1:0]  OCOL_LAST  = CW'(OUT_W - 1);
  localparam logic [RW-1:0]  OROW_LAST  = RW'(OUT_H - 1);
  localparam logic [PHW-1:0] PH_LAST    = PHW'(STRIDE - 1);

  // Pixel position of the next accepted beat, and its stride phase.
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PHW-1:0] col_ph_q, col_ph_d;
  logic [PHW-1:0] row_ph_q, row_ph_d;

  // Index of the next window to be emitted.
  logic [CW-1:0]  wcol_q, wcol_d;
  logic [RW-1:0]  wrow_q, wrow_d;

  // Registered outputs.
  logic                 ovalid_q, ovalid_d;
  logic [K*K*PW-1:0]    odata_q, odata_d;
  logic                 osof_q, osof_d;
  logic                 oeof_q, oeof_d;
  logic [RW-1:0]        orow_q, orow_d;
  logic [CW-1:0]        ocol_q, ocol_d;

  // Data path storage: never reset, stale contents are never exposed because a
  // window needs K fresh columns and K-1 fresh rows.
  logic [PW-1:0] lb_q  [K-1][IMG_W];
  logic [PW-1:0] lb_d  [K-1][IMG_W];
  logic [PW-1:0] win_q [K][K];
  logic [PW-1:0] win_d [K][K];

  logic [PW-1:0] new_col [K];
  logic          complete;

  // Incoming right-hand window column. Line buffer j delays by (j+1) rows, so
  // its tail is the pixel j+1 rows above the current one.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      new_col[r] = '0;
    end
    new_col[K-1] = idata;
    for (int j = 0; j < K-1; j++) begin
      new_col[K-2-j] = lb_q[j][IMG_W-1];
    end
  end

  // A clear beat always lands on (0,0), which can never complete a window.
  assign complete = ivalid && !iclear &&
                    (row_q >= ROW_START) && (col_q >= COL_START) &&
                    (row_ph_q == '0) && (col_ph_q == '0);

  always_comb begin
    lb_d     = lb_q;
    win_d    = win_q;
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    wcol_d   = wcol_q;
    wrow_d   = wrow_q;
    ovalid_d = 1'b0;
    odata_d  = odata_q;
    osof_d   = osof_q;
    oeof_d   = oeof_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;

    // Storage shifts on every accepted pixel, including a clear beat.
    if (ivalid) begin
      for (int j = 0; j < K-1; j++) begin
        for (int i = IMG_W-1; i > 0; i--) begin
          lb_d[j][i] = lb_q[j][i-1];
        end
      end
      lb_d[0][0] = idata;
      for (int j = 1; j < K-1; j++) begin
        lb_d[j][0] = lb_q[j-1][IMG_W-1];
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = new_col[r];
      end
    end

    if (iclear) begin
      col_d    = '0;
      row_d    = '0;
      col_ph_d = '0;
      row_ph_d = '0;
      wcol_d   = '0;
      wrow_d   = '0;
      // The accompanying pixel is (0,0); IMG_W >= 2 so no wrap is possible.
      if (ivalid) begin
        col_d = CW'(1);
      end
    end else if (ivalid) begin
      if (col_q == COL_LAST) begin
        col_d    = '0;
        col_ph_d = '0;
        if (row_q == ROW_LAST) begin
          row_d    = '0;
          row_ph_d = '0;
        end else begin
          row_d = row_q + RW'(1);
          // Phase is relative to row K-1; rows up to K-1 sit at phase 0.
          if (row_q < ROW_START) begin
            row_ph_d = '0;
          end else begin
            row_ph_d = (row_ph_q == PH_LAST) ? '0 : row_ph_q + PHW'(1);
          end
        end
      end else begin
        col_d = col_q + CW'(1);
        if (col_q < COL_START) begin
          col_ph_d = '0;
        end else begin
          col_ph_d = (col_ph_q == PH_LAST) ? '0 : col_ph_q + PHW'(1);
        end
      end

      if (complete) begin
        ovalid_d = 1'b1;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            odata_d[(r*K+c)*PW +: PW] = win_d[r][c];
          end
        end
        orow_d = wrow_q;
        ocol_d = wcol_q;
        osof_d = (wrow_q == '0) && (wcol_q == '0);
        oeof_d = (wrow_q == OROW_LAST) && (wcol_q == OCOL_LAST);
        if (wcol_q == OCOL_LAST) begin
          wcol_d = '0;
          wrow_d = (wrow_q == OROW_LAST) ? '0 : wrow_q + RW'(1);
        end else begin
          wcol_d = wcol_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
      wcol_q   <= '0;
      wrow_q   <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      osof_q   <= 1'b0;
      oeof_q   <= 1'b0;
      orow_q   <= '0;
      ocol_q   <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
      wcol_q   <= wcol_d;
      wrow_q   <= wrow_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      osof_q   <= osof_d;
      oeof_q   <= oeof_d;
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
    end
  end

  always_ff @(posedge clk) begin
    lb_q  <= lb_d;
    win_q <= win_d;
  end

  assign ovalid = ovalid_q;
  assign odata  = odata_q;
  assign osof   = osof_q;
  assign oeof   = oeof_q;
  assign orow   = orow_q;
  assign ocol   = ocol_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
//
// Three instances share one clock:
//   a: default parameters (K=3, 9x9, STRIDE=1, 6-bit samples)
//   b: STRIDE=2
//   c: CH=2, 5x5, 8-bit samples
// The bench keeps its own copy of every pixel written in the current frame,
// decides from the raster position whether a window completes, and pushes the
// expected window (data, flags, indices, arrival cycle) to a per-instance
// queue. Monitors pop and compare on every ovalid pulse.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

  typedef struct packed {
    logic [143:0] data;
    logic         sof;
    logic         eof;
    logic [7:0]   orow;
    logic [7:0]   ocol;
    logic [31:0]  cyc;
  } exp_t;

  // Clock / reset / cycle counter
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a
  logic        rst_a, iclear_a, ivalid_a;
  logic [5:0]  idata_a;
  logic        ovalid_a, osof_a, oeof_a;
  logic [53:0] odata_a;
  logic [3:0]  orow_a, ocol_a;
  // Instance b
  logic        rst_b, iclear_b, ivalid_b;
  logic [5:0]  idata_b;
  logic        ovalid_b, osof_b, oeof_b;
  logic [53:0] odata_b;
  logic [3:0]  orow_b, ocol_b;
  // Instance c
  logic         rst_c, iclear_c, ivalid_c;
  logic [15:0]  idata_c;
  logic         ovalid_c, osof_c, oeof_c;
  logic [143:0] odata_c;
  logic [2:0]   orow_c, ocol_c;

  conv_window_gen #(.DATA_WIDTH(6), .K(3), .CH(1), .IMG_W(9), .IMG_H(9), .STRIDE(1)) u_a (
    .clk(clk), .rst(rst_a), .iclear(iclear_a), .ivalid(ivalid_a), .idata(idata_a),
    .ovalid(ovalid_a), .odata(odata_a), .osof(osof_a), .oeof(oeof_a),
    .orow(orow_a), .ocol(ocol_a));

  conv_window_gen #(.DATA_WIDTH(6), .K(3), .CH(1), .IMG_W(9), .IMG_H(9), .STRIDE(2)) u_b (
    .clk(clk), .rst(rst_b), .iclear(iclear_b), .ivalid(ivalid_b), .idata(idata_b),
    .ovalid(ovalid_b), .odata(odata_b), .osof(osof_b), .oeof(oeof_b),
    .orow(orow_b), .ocol(ocol_b));

  conv_window_gen #(.DATA_WIDTH(8), .K(3), .CH(2), .IMG_W(5), .IMG_H(5), .STRIDE(1)) u_c (
    .clk(clk), .rst(rst_c), .iclear(iclear_c), .ivalid(ivalid_c), .idata(idata_c),
    .ovalid(ovalid_c), .odata(odata_c), .osof(osof_c), .oeof(oeof_c),
    .orow(orow_c), .ocol(ocol_c));

  // Scoreboard state
  exp_t exp_a_q[$];
  exp_t exp_b_q[$];
  exp_t exp_c_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_win[3];
  int n_sof[3];
  int n_eof[3];
  int img[3][9][9];
  int m_row[3];
  int m_col[3];

  task automatic get_par(input int id, output int k, output int w, output int h,
                         output int s, output int pw);
    k = 3;
    case (id)
      0:       begin w = 9; h = 9; s = 1; pw = 6;  end
      1:       begin w = 9; h = 9; s = 2; pw = 6;  end
      default: begin w = 5; h = 5; s = 1; pw = 16; end
    endcase
  endtask

  // Reference model: record the pixel at its raster position, emit a window
  // when the position lies on the stride grid.
  task automatic model_accept(input int id, input int pix, input bit clr);
    int k, w, h, s, pw, r, c, wr, wc;
    logic [143:0] d;
    exp_t e;
    get_par(id, k, w, h, s, pw);
    if (clr) begin
      m_row[id] = 0;
      m_col[id] = 0;
    end
    r = m_row[id];
    c = m_col[id];
    img[id][r][c] = pix;
    if (r >= k-1 && c >= k-1 && (r-k+1) % s == 0 && (c-k+1) % s == 0) begin
      wr = (r-k+1) / s;
      wc = (c-k+1) / s;
      d = '0;
      for (int rr = 0; rr < k; rr++) begin
        for (int cc = 0; cc < k; cc++) begin
          d = d | (144'(img[id][r-k+1+rr][c-k+1+cc]) << ((rr*k+cc)*pw));
        end
      end
      e.data = d;
      e.sof  = (wr == 0 && wc == 0);
      e.eof  = (wr == (h-k)/s && wc == (w-k)/s);
      e.orow = 8'(wr);
      e.ocol = 8'(wc);
      e.cyc  = 32'(cyc + 1);
      case (id)
        0:       exp_a_q.push_back(e);
        1:       exp_b_q.push_back(e);
        default: exp_c_q.push_back(e);
      endcase
    end
    if (c == w-1) begin
      m_col[id] = 0;
      m_row[id] = (r == h-1) ? 0 : r + 1;
    end else begin
      m_col[id] = c + 1;
    end
  endtask

  // Driver tasks
  task automatic send(input int id, input int v, input bit clr);
    @(negedge clk);
    case (id)
      0: begin
        ivalid_a = 1'b1; iclear_a = clr; idata_a = 6'(v);
        model_accept(0, v % 64, clr);
      end
      1: begin
        ivalid_b = 1'b1; iclear_b = clr; idata_b = 6'(v);
        model_accept(1, v % 64, clr);
      end
      default: begin
        ivalid_c = 1'b1; iclear_c = clr; idata_c = {8'(100 + v), 8'(v)};
        model_accept(2, (((100 + v) % 256) << 8) | (v % 256), clr);
      end
    endcase
  endtask

  // Gap cycle: random data on idle inputs must not matter.
  task automatic idle();
    @(negedge clk);
    ivalid_a = 1'b0; iclear_a = 1'b0; idata_a = 6'($urandom_range(0, 63));
    ivalid_b = 1'b0; iclear_b = 1'b0; idata_b = 6'($urandom_range(0, 63));
    ivalid_c = 1'b0; iclear_c = 1'b0; idata_c = 16'($urandom_range(0, 65535));
  endtask

  task automatic check_eq(input string tag, input logic [143:0] obs, input logic [143:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_counts(input int id);
    n_win[id] = 0;
    n_sof[id] = 0;
    n_eof[id] = 0;
  endtask

  // Scoreboard compare, called on every ovalid pulse.
  task automatic check_win(input int id, input logic [143:0] d, input logic sof,
                           input logic eof, input logic [7:0] r, input logic [7:0] c);
    exp_t e;
    int have;
    n_win[id]++;
    if (sof) n_sof[id]++;
    if (eof) n_eof[id]++;
    case (id)
      0:       have = exp_a_q.size();
      1:       have = exp_b_q.size();
      default: have = exp_c_q.size();
    endcase
    n_cmp++;
    assert (have > 0) else begin
      n_bad++;
      $error("FAIL win%0d_unexpected observed=ovalid at cycle %0d expected=no window", id, cyc);
    end
    if (have > 0) begin
      case (id)
        0:       e = exp_a_q.pop_front();
        1:       e = exp_b_q.pop_front();
        default: e = exp_c_q.pop_front();
      endcase
      n_cmp++;
      assert ({d, sof, eof, r, c} === {e.data, e.sof, e.eof, e.orow, e.ocol}) else begin
        n_bad++;
        $error("FAIL win%0d_content observed=%h sof=%b eof=%b row=%0d col=%0d expected=%h sof=%b eof=%b row=%0d col=%0d",
               id, d, sof, eof, r, c, e.data, e.sof, e.eof, e.orow, e.ocol);
      end
      n_cmp++;
      assert (32'(cyc) === e.cyc) else begin
        n_bad++;
        $error("FAIL win%0d_latency observed=cycle %0d expected=cycle %0d", id, cyc, e.cyc);
      end
    end
  endtask

  // Monitors
  always @(negedge clk) if (ovalid_a === 1'b1)
    check_win(0, 144'(odata_a), osof_a, oeof_a, 8'(orow_a), 8'(ocol_a));
  always @(negedge clk) if (ovalid_b === 1'b1)
    check_win(1, 144'(odata_b), osof_b, oeof_b, 8'(orow_b), 8'(ocol_b));
  always @(negedge clk) if (ovalid_c === 1'b1)
    check_win(2, odata_c, osof_c, oeof_c, 8'(orow_c), 8'(ocol_c));

  task automatic check_a_zero(input string tag);
    check_eq({tag, "_ovalid"}, 144'(ovalid_a), '0);
    check_eq({tag, "_odata"},  144'(odata_a),  '0);
    check_eq({tag, "_osof"},   144'(osof_a),   '0);
    check_eq({tag, "_oeof"},   144'(oeof_a),   '0);
    check_eq({tag, "_orow"},   144'(orow_a),   '0);
    check_eq({tag, "_ocol"},   144'(ocol_a),   '0);
  endtask

  task automatic check_totals(input int id, input string tag, input int wins,
                              input int sofs, input int eofs);
    check_eq({tag, "_windows"}, 144'(n_win[id]), 144'(wins));
    check_eq({tag, "_sof_count"}, 144'(n_sof[id]), 144'(sofs));
    check_eq({tag, "_eof_count"}, 144'(n_eof[id]), 144'(eofs));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ivalid_a = 1'b0; iclear_a = 1'b0; idata_a = '0;
    ivalid_b = 1'b0; iclear_b = 1'b0; idata_b = '0;
    ivalid_c = 1'b0; iclear_c = 1'b0; idata_c = '0;
    for (int i = 0; i < 3; i++) begin
      m_row[i] = 0;
      m_col[i] = 0;
      clear_counts(i);
    end

    // Reset values
    repeat (3) @(negedge clk);
    check_a_zero("reset_a");
    check_eq("reset_b_outputs", 144'({ovalid_b, odata_b, osof_b, oeof_b, orow_b, ocol_b}), '0);
    check_eq("reset_c_outputs", 144'({ovalid_c, osof_c, oeof_c, orow_c, ocol_c}), '0);
    check_eq("reset_c_odata", odata_c, '0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(negedge clk);

    // Continuous frame
    clear_counts(0);
    for (int i = 0; i < 81; i++) send(0, i, 1'b0);
    repeat (3) idle();
    check_totals(0, "a_frame", 49, 1, 1);

    // Same frame with alternating gaps
    clear_counts(0);
    for (int i = 0; i < 81; i++) begin
      send(0, i, 1'b0);
      idle();
    end
    repeat (3) idle();
    check_totals(0, "a_gapped", 49, 1, 1);

    // Two back-to-back frames
    clear_counts(0);
    for (int i = 0; i < 162; i++) send(0, i % 81, 1'b0);
    repeat (3) idle();
    check_totals(0, "a_two_frames", 98, 2, 2);

    // Reset mid-frame, then restart at pixel 0
    for (int i = 0; i < 31; i++) send(0, i, 1'b0);
    repeat (2) idle();
    rst_a = 1'b1;
    #1;
    check_a_zero("midrst_async");
    repeat (2) @(negedge clk);
    check_a_zero("midrst_held");
    rst_a = 1'b0;
    m_row[0] = 0;
    m_col[0] = 0;
    clear_counts(0);
    for (int i = 0; i < 81; i++) send(0, i, 1'b0);
    repeat (3) idle();
    check_totals(0, "a_after_rst", 49, 1, 1);

    // iclear alongside the 31st pixel: 8 windows from the abandoned
    // frame, then a full restarted frame.
    clear_counts(0);
    for (int i = 0; i < 30; i++) send(0, i, 1'b0);
    send(0, 0, 1'b1);
    for (int i = 1; i < 81; i++) send(0, i, 1'b0);
    repeat (3) idle();
    check_totals(0, "a_iclear", 57, 2, 1);

    // STRIDE=2
    clear_counts(1);
    for (int i = 0; i < 81; i++) send(1, i, 1'b0);
    repeat (3) idle();
    check_totals(1, "b_stride2", 16, 1, 1);

    // CH=2, 5x5
    clear_counts(2);
    for (int i = 0; i < 25; i++) send(2, i, 1'b0);
    repeat (3) idle();
    check_totals(2, "c_two_channels", 9, 1, 1);

    // Every expected window must have been delivered.
    check_eq("a_queue_drained", 144'(exp_a_q.size()), '0);
    check_eq("b_queue_drained", 144'(exp_b_q.size()), '0);
    check_eq("c_queue_drained", 144'(exp_c_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming K×K sliding-window generator for the BNN accelerator convolution front end. It accepts one multi-channel pixel per valid beat in raster order. It buffers K-1 image rows and presents a full K×K×CH window whenever the newest pixel completes a window on the configured stride grid. It tracks frame position internally, flags the first and last window of each frame, and supports a synchronous frame restart. It feeds the binary MAC array directly.

## Interface

- DATA_WIDTH, 6, bits per channel sample
- K, 3, window edge (K ≥ 2)
- CH, 1, channels packed per pixel (CH ≥ 1)
- IMG_W, 9, image width in pixels (IMG_W ≥ K)
- IMG_H, 9, image height in pixels (IMG_H ≥ K)
- STRIDE, 1, window step in both axes (STRIDE ≥ 1)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- iclear  input  1  synchronous frame restart
- ivalid  input  1  idata valid this cycle
- idata  input  CH*DATA_WIDTH  pixel; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- ovalid  output  1  odata holds a valid window
- odata  output  K*K*CH*DATA_WIDTH  window; element (r,c) at [((r*K+c)*CH*DATA_WIDTH) +: CH*DATA_WIDTH]; r=0 is the oldest row, c=0 is the leftmost column
- osof  output  1  first window of frame (qualified by ovalid)
- oeof  output  1  last window of frame (qualified by ovalid)
- orow  output  clog2(IMG_H)  output-window row index
- ocol  output  clog2(IMG_W)  output-window column index

## Operation

- Storage: K-1 line buffers of IMG_W pixels each (shift registers or RAM), plus a K×K pixel window register. Every accepted pixel shifts the window left by one column. The new right column is the K-1 buffered pixels of the current column followed by idata.
- Position counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing only on ivalid. At col=IMG_W-1, col wraps to 0 and row increments. At the last pixel of the frame, both counters return to 0 with no gap cycle.
- The window is complete when all of the following hold for the accepted pixel: row ≥ K-1, col ≥ K-1, (row-(K-1)) mod STRIDE = 0, and (col-(K-1)) mod STRIDE = 0. Use stride phase counters rather than dividers.
- Windows per frame: OUT_W = (IMG_W-K)/STRIDE+1 and OUT_H = (IMG_H-K)/STRIDE+1, with integer division. Trailing pixels off the stride grid produce no window.
- orow and ocol count output windows: 0..OUT_H-1 and 0..OUT_W-1.
- osof is asserted when orow=0 and ocol=0.
- oeof is asserted when orow=OUT_H-1 and ocol=OUT_W-1.
- There is no horizontal padding. Windows never span a row boundary, because col ≥ K-1 is required.
- Line buffer contents are not cleared at frame wrap, on iclear, or on reset. Stale data is never exposed, because a window needs K-1 fresh rows.
- iclear forces col, row, stride phase, orow and ocol to 0.
- iclear asserted together with ivalid: clear wins, and idata is accepted as pixel (0,0) of the new frame.
- No back-pressure: the consumer must accept every ovalid beat. ivalid may have arbitrary gaps. Output content is independent of gap pattern.

## Timing

- Reset values: ovalid, osof, oeof, orow, ocol and odata are all 0. All counters are 0.
- Latency: ovalid, odata, osof, oeof, orow and ocol are registered. They assert on the cycle after the clock edge that accepts the completing pixel.
- ovalid is a single-cycle pulse per window. odata holds its value until the next window; it is don't-care when ovalid=0, but in practice holds its last value.
- Throughput: one pixel per cycle sustained. With STRIDE=1, windows can be emitted back to back.
- rst mid-frame: all outputs drop to 0 asynchronously. The next accepted pixel is (0,0).
- iclear does not cancel a window already registered on the same edge. That ovalid still appears.

## Test plan

- Default parameters, idata=i for i=0..80, ivalid held high → 49 windows. The first window appears one cycle after pixel 20 is accepted, with (0,0)=0, (0,2)=2, (1,0)=9, (2,2)=20, and osof=1. The last window has (2,2)=80, oeof=1, orow=6, ocol=6.
- Same stream with ivalid alternating 1/0 → identical window sequence and contents. Each ovalid lands one cycle after its completing beat.
- STRIDE=2 → 16 windows. The first completes at pixel 20, the second at pixel 22, the fifth at pixel 38 (orow=1, ocol=0). oeof=1 at orow=3, ocol=3, where (2,2)=80.
- CH=2, IMG_W=IMG_H=5, channel0=i and channel1=100+i → 9 windows. In the first window, element (2,2) is {100+12, 12}.
- Two back-to-back frames with no idle cycle → 98 windows. osof asserts at indices 0 and 49; oeof asserts at indices 48 and 97.
- Assert rst after pixel 30, then restart the stream at 0 → outputs are 0 during reset, and the first window after restart has (2,2)=20. Repeat the test with iclear asserted alongside ivalid on pixel 30 → same result.
